rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Grant is issued as a 3-bit index, decoded to a one-hot 8-bit grant vector.
- Sits in front of any shared datapath (bus, display digit, memory port) that needs one owner at a time.
- Grant is held until the owner signals done, withdraws its request, or exceeds a configurable hold limit.

---
 rtl/rr_arbiter_8_pkg.sv | 17 +
 rtl/rr_arbiter_8_if.sv | 28 ++
 rtl/rr_arbiter_8_decoder_3to8.sv | 13 +
 rtl/rr_arbiter_8.sv | 115 +++++++++++
 tb/tb_rr_arbiter_8.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
//   state_e  : FSM state encoding (IDLE / GRANT)
//   NUM_REQ  : number of requesters
//   IDX_W    : width of a requester index
//   HOLD_W   : width of the saturating hold counter
package rr_arbiter_8_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int HOLD_W  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters and the arbiter.
//   req         : request vector, bit i = requester i wants the resource
//   done        : current owner finished
//   grant       : one-hot grant, zero when no owner
//   grant_idx   : index of the current owner (meaningful while grant_valid)
//   grant_valid : an owner holds the grant
//   timeout     : one-cycle pulse when the hold limit revokes a grant
// master = requester side, slave = arbiter side.
interface rr_arbiter_8_if;
    import rr_arbiter_8_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               timeout;

    modport master (
        output req, done,
        input  grant, grant_idx, grant_valid, timeout
    );

    modport slave (
        input  req, done,
        output grant, grant_idx, grant_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter_8_decoder_3to8.sv
// Plain 3-to-8 binary decoder.
//   a_i : binary index (bit 0 = A0)
//   y_o : one-hot output, y_o[n] = Yn
module decoder_3to8
    import rr_arbiter_8_pkg::*;
(
    input  logic [IDX_W-1:0]   a_i,
    output logic [NUM_REQ-1:0] y_o
);

    assign y_o = NUM_REQ'(1) << a_i;

endmodule

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter sharing one resource among 8 requesters.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : request/grant bundle (slave side), see rr_arbiter_8_if
// MAX_HOLD limits how many consecutive cycles one owner may keep the
// grant (0 = unlimited).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no owner; pick first requester at or after ptr on next edge
// GRANT | owner grant_idx holds the resource until done/withdraw/limit
module rr_arbiter_8
    import rr_arbiter_8_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rst,
    rr_arbiter_8_if.slave bus
);

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_EN ? HOLD_W'(MAX_HOLD - 1) : '0;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                valid_q, valid_d;
    logic                timeout_q, timeout_d;

    logic [IDX_W-1:0]    sel;
    logic [IDX_W-1:0]    cand;
    logic                found;
    logic                rel_done, rel_drop, rel_limit;
    logic [NUM_REQ-1:0]  dec_y;

    // Rotating-priority scan: first set request starting at ptr, wrapping.
    always_comb begin
        sel   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr_q + IDX_W'(k);
            if (!found && bus.req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    assign rel_done  = bus.done;
    assign rel_drop  = !bus.req[idx_q];
    assign rel_limit = HOLD_EN && (hold_q == HOLD_LAST);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = GRANT;
                    idx_d   = sel;
                    valid_d = 1'b1;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (rel_done || rel_drop || rel_limit) begin
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                    ptr_d     = idx_q + 1'b1;
                    // Only a pure limit expiry counts as a forced revoke.
                    timeout_d = rel_limit && !rel_done && !rel_drop;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    decoder_3to8 u_dec (
        .a_i (idx_q),
        .y_o (dec_y)
    );

    assign bus.grant       = dec_y & {NUM_REQ{valid_q}};
    assign bus.grant_idx   = idx_q;
    assign bus.grant_valid = valid_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
module tb_rr_arbiter_8;

    logic clk;
    logic rst;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] idx;
        logic       valid;
        logic       to;
        logic       chk_idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Drive inputs for the next rising edge and queue the outputs expected after it.
    task automatic step(input logic r, input logic [7:0] rq, input logic d,
                        input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et, input logic ci);
        exp_t e;
        @(negedge clk);
        rst      = r;
        bus.req  = rq;
        bus.done = d;
        e.grant   = eg;
        e.idx     = ei;
        e.valid   = ev;
        e.to      = et;
        e.chk_idx = ci | ev;
        q.push_back(e);
    endtask

    task automatic gr(input logic [7:0] rq, input logic d, input logic [2:0] ei, input logic [7:0] eg);
        step(1'b0, rq, d, eg, ei, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic zr(input logic [7:0] rq, input logic d, input logic et);
        step(1'b0, rq, d, 8'h00, 3'd0, 1'b0, et, 1'b0);
    endtask

    task automatic rs(input logic [7:0] rq, input logic d);
        step(1'b1, rq, d, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    endtask

    // Monitor: compare DUT outputs after each edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (bus.grant !== e.grant || bus.grant_valid !== e.valid ||
                    bus.timeout !== e.to || (e.chk_idx && bus.grant_idx !== e.idx)) begin
                    errors++;
                    $display("FAIL out cyc=%0d: got grant=%h idx=%0d valid=%b to=%b, want grant=%h idx=%0d valid=%b to=%b",
                             cyc, bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout,
                             e.grant, e.idx, e.valid, e.to);
                end
                checks++;
                if (!$onehot0(bus.grant)) begin
                    errors++;
                    $display("FAIL onehot cyc=%0d: got grant=%h, want at most one bit", cyc, bus.grant);
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        bus.req  = 8'h00;
        bus.done = 1'b0;

        rs(8'h00, 1'b0);
        rs(8'h00, 1'b0);

        // idle with no requests
        repeat (5) zr(8'h00, 1'b0, 1'b0);

        // req 0x24 from ptr 0: idx 2, done, then idx 5
        gr(8'h24, 1'b0, 3'd2, 8'h04);
        zr(8'h24, 1'b1, 1'b0);
        gr(8'h24, 1'b0, 3'd5, 8'h20);
        zr(8'h24, 1'b1, 1'b0);
        zr(8'h00, 1'b0, 1'b0);

        // hold limit 4 on requester 0, timeout, re-grant after one idle cycle
        repeat (4) gr(8'h01, 1'b0, 3'd0, 8'h01);
        zr(8'h01, 1'b0, 1'b1);
        gr(8'h01, 1'b0, 3'd0, 8'h01);
        zr(8'h00, 1'b0, 1'b0);

        // bring ptr to 0 via a grant to 7 (wrap)
        gr(8'h80, 1'b0, 3'd7, 8'h80);
        zr(8'h80, 1'b1, 1'b0);

        // all requesting: 0..7,0 with an idle cycle between each
        for (int k = 0; k < 9; k++) begin
            gr(8'hFF, 1'b0, 3'(k % 8), 8'h01 << (k % 8));
            zr(8'hFF, 1'b1, 1'b0);
        end

        // owner 3 withdraws while 6 waits; no pre-emption before that
        gr(8'h08, 1'b0, 3'd3, 8'h08);
        gr(8'h48, 1'b0, 3'd3, 8'h08);
        zr(8'h40, 1'b0, 1'b0);
        gr(8'h40, 1'b0, 3'd6, 8'h40);

        // reset on the edge where done and the hold limit coincide
        repeat (3) gr(8'h40, 1'b0, 3'd6, 8'h40);
        rs(8'h40, 1'b1);
        gr(8'h80, 1'b0, 3'd7, 8'h80);
        zr(8'h80, 1'b1, 1'b0);

        // reset mid-grant restarts the pointer at 0
        gr(8'h04, 1'b0, 3'd2, 8'h04);
        rs(8'h0C, 1'b0);
        gr(8'h0C, 1'b0, 3'd2, 8'h04);
        zr(8'h0C, 1'b1, 1'b0);

        // done on the limit edge suppresses timeout
        repeat (4) gr(8'h08, 1'b0, 3'd3, 8'h08);
        zr(8'h08, 1'b1, 1'b0);
        zr(8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
